// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: picks one LED mode driver, keeps the rest in reset, and steps modes on a debounced press or a dwell timeout with a dark gap between modes.
module led_mode_sequencer #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int DWELL_CYCLES    = 60000000,
    parameter int BLANK_CYCLES    = 1200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_n,
    input  logic        auto_en,
    input  logic [31:0] mode_led_bus,
    output logic [3:0]  drv_rst_n,
    output logic [1:0]  mode_sel,
    output logic [7:0]  led_out,
    output logic        mode_change
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW_W = $clog2(DWELL_CYCLES + 1);
    localparam int BL_W = $clog2(BLANK_CYCLES + 1);

    typedef enum logic {BLANK, RUN} state_t;

    state_t            state;
    logic              btn_s0, btn_s1, btn_stable;
    logic [DB_W-1:0]   db_cnt;
    logic [DW_W-1:0]   dwell_cnt;
    logic [BL_W-1:0]   blank_cnt;
    logic              db_hit, press, dwell_hit;
    logic [1:0]        next_mode;
    logic [3:0]        sel_onehot;

    assign db_hit     = (btn_s1 != btn_stable) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign press      = db_hit && !btn_s1;
    assign dwell_hit  = auto_en && (dwell_cnt == DW_W'(DWELL_CYCLES - 1));
    assign next_mode  = (mode_sel == 2'(NUM_MODES - 1)) ? 2'd0 : mode_sel + 2'd1;
    assign sel_onehot = 4'b0001 << mode_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s0     <= 1'b1;
            btn_s1     <= 1'b1;
            btn_stable <= 1'b1;
            db_cnt     <= '0;
        end else begin
            btn_s0 <= btn_n;
            btn_s1 <= btn_s0;
            if (btn_s1 == btn_stable)
                db_cnt <= '0;
            else if (db_hit) begin
                btn_stable <= btn_s1;
                db_cnt     <= '0;
            end else
                db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BLANK;
            blank_cnt   <= '0;
            dwell_cnt   <= '0;
            mode_sel    <= 2'd0;
            led_out     <= 8'h00;
            drv_rst_n   <= 4'b0000;
            mode_change <= 1'b0;
        end else begin
            mode_change <= 1'b0;
            if (state == BLANK) begin
                led_out   <= 8'h00;
                drv_rst_n <= 4'b0000;
                if (blank_cnt == BL_W'(BLANK_CYCLES - 1)) begin
                    state     <= RUN;
                    blank_cnt <= '0;
                    drv_rst_n <= sel_onehot;
                end else
                    blank_cnt <= blank_cnt + BL_W'(1);
            end else if (press || dwell_hit) begin
                // press and dwell expiry on the same cycle collapse into one advance
                state       <= BLANK;
                mode_sel    <= next_mode;
                dwell_cnt   <= '0;
                mode_change <= 1'b1;
                led_out     <= 8'h00;
                drv_rst_n   <= 4'b0000;
            end else begin
                led_out   <= mode_led_bus[{mode_sel, 3'b000} +: 8];
                drv_rst_n <= sel_onehot;
                dwell_cnt <= auto_en ? dwell_cnt + DW_W'(1) : '0;
            end
        end
    end
endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer: directed scenarios with a mode-advance scoreboard for led_mode_sequencer.
module tb_led_mode_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, btn_n, auto_en;
    logic [31:0] mode_led_bus;
    logic [3:0]  drv_rst_n;
    logic [1:0]  mode_sel;
    logic [7:0]  led_out;
    logic        mode_change;
    logic [7:0]  stub0, stub1, stub2;
    logic [1:0]  exp_q[$];
    int          compared = 0;
    int          mismatched = 0;

    led_mode_sequencer #(
        .NUM_MODES(3), .DEBOUNCE_CYCLES(4), .DWELL_CYCLES(50), .BLANK_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .auto_en(auto_en),
        .mode_led_bus(mode_led_bus), .drv_rst_n(drv_rst_n), .mode_sel(mode_sel),
        .led_out(led_out), .mode_change(mode_change)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        stub0 <= drv_rst_n[0] ? 8'h11 : 8'h00;
        stub1 <= drv_rst_n[1] ? 8'h22 : 8'h00;
        stub2 <= drv_rst_n[2] ? 8'h33 : 8'h00;
    end
    assign mode_led_bus = {8'hEE, stub2, stub1, stub0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every advance pops the mode the stimulus predicted
    always @(negedge clk) begin
        if (mode_change === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL unexpected_change: observed mode_sel %0d expected no advance", mode_sel);
            end else
                chk("sb_mode_sel", 32'(mode_sel), 32'(exp_q.pop_front()));
        end
    end

    task automatic startup(input string tag);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i <= 7) chk({tag, "_dark"}, 32'({drv_rst_n, led_out, mode_change}), 0);
            if (i == 8) chk({tag, "_drv"}, 32'(drv_rst_n), 1);
            if (i == 9) chk({tag, "_led_lat"}, 32'(led_out), 0);
            if (i == 10) chk({tag, "_led"}, 32'(led_out), 'h11);
        end
    endtask

    task automatic press_track(input int hold, input logic [1:0] es, input int el, input string tag);
        int pulses, tc, tr;
        pulses = 0; tc = -1; tr = -1;
        exp_q.push_back(es);
        btn_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == hold - 1) btn_n = 1'b1;
            if (mode_change) begin pulses++; tc = i; end
            if (tc >= 0 && tr < 0 && drv_rst_n != 4'b0000) tr = i;
        end
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_blank_len"}, tr - tc, 8);
        chk({tag, "_drv"}, 32'(4'b0001 << es), 32'(drv_rst_n));
        chk({tag, "_mode"}, 32'(mode_sel), 32'(es));
        chk({tag, "_led"}, 32'(led_out), el);
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (mode_change) begin n = i; break; end
        end
    endtask

    initial begin
        int n, pulses, tc;
        rst_n = 1'b0; btn_n = 1'b1; auto_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'({mode_sel, led_out, drv_rst_n, mode_change}), 0);
        rst_n = 1'b1;
        startup("boot");
        pulses = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (mode_change) pulses++; end
        chk("boot_steady_pulses", pulses, 0);
        chk("boot_steady_led", 32'(led_out), 'h11);

        press_track(10, 2'd1, 'h22, "press1");
        btn_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (mode_change) pulses++; end
        chk("glitch_pulses", pulses, 0);
        chk("glitch_mode", 32'(mode_sel), 1);

        press_track(10, 2'd2, 'h33, "press2");
        press_track(10, 2'd0, 'h11, "press_wrap");
        press_track(10, 2'd1, 'h22, "press3");

        auto_en = 1'b1;
        exp_q.push_back(2'd2);
        wait_pulse(100, n);
        chk("auto_first_delay", n, 50);
        exp_q.push_back(2'd0);
        wait_pulse(100, n);
        chk("auto_period", n, 58);
        exp_q.push_back(2'd1);
        pulses = 0; tc = -1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (mode_change) begin pulses++; tc = i; end
            if (i == 52) btn_n = 1'b0;
            if (i == 62) btn_n = 1'b1;
        end
        auto_en = 1'b0;
        chk("coincide_pulses", pulses, 1);
        chk("coincide_time", tc, 58);
        chk("coincide_mode", 32'(mode_sel), 1);

        auto_en = 1'b1;
        exp_q.push_back(2'd2);
        pulses = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (mode_change) pulses++;
            if (i == 46) btn_n = 1'b0;
            if (i == 56) btn_n = 1'b1;
            if (i == 60) auto_en = 1'b0;
        end
        chk("blank_press_pulses", pulses, 1);
        chk("blank_press_mode", 32'(mode_sel), 2);
        chk("blank_press_led", 32'(led_out), 'h33);
        chk("blank_press_drv", 32'(drv_rst_n), 4);

        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset", 32'({mode_sel, led_out, drv_rst_n, mode_change}), 0);
        rst_n = 1'b1;
        startup("recover");
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Top-level scheduler for the heartbeat-light LED mode drivers on the 12 MHz board clock. Selects one of up to four mode drivers and routes its 8-bit pattern to the LED pins. Holds every unselected driver in synchronous reset, so the selected pattern always starts from its beginning. Advances modes on a debounced push-button press, or on a dwell timer when auto-cycle is enabled, and inserts a blank gap between modes.

Parameters:
NUM_MODES, 4, number of attached drivers (legal 2..4); slices of mode_led_bus above NUM_MODES-1 are ignored
DEBOUNCE_CYCLES, 240000, cycles the synchronized button must stay stable before it is accepted (20 ms)
DWELL_CYCLES, 60000000, cycles spent in RUN before an auto-advance (5 s)
BLANK_CYCLES, 1200000, length of the dark gap between modes (100 ms); must be ≥1

Ports:
clk  in  1  12 MHz system clock; single clock domain
rst_n  in  1  reset, synchronous, active-low
btn_n  in  1  raw push-button, active-low, asynchronous to clk
auto_en  in  1  1 = auto-cycle on dwell expiry
mode_led_bus  in  32  driver outputs; driver k occupies bits [8k+7:8k]
drv_rst_n  out  4  per-driver synchronous active-low reset
mode_sel  out  2  index of the current or next mode
led_out  out  8  registered LED pattern
mode_change  out  1  one-cycle pulse on each advance

Behaviour:
- Reset (rst_n=0 at a clk edge): state=BLANK, blank_cnt=0, dwell_cnt=0, mode_sel=0, led_out=0, drv_rst_n=4'b0000, mode_change=0. Debounce synchronizer and stable level reset to 1 (released). The debounce counter resets to 0.
- Reset mid-operation aborts any state and applies the values above on the same edge. No press event is generated on exit.
- Button path: btn_n passes through a 2-flop synchronizer. A counter increments while the synchronized value differs from the stable level, and clears when they match. On reaching DEBOUNCE_CYCLES-1 the stable level takes the synchronized value. A press is a single-cycle event on a stable 1→0 transition. Release generates no event.
- States:
  - BLANK: led_out=0 and drv_rst_n=0000. blank_cnt counts 0..BLANK_CYCLES-1. At the count BLANK_CYCLES-1, the next state is RUN and blank_cnt clears. Press events and dwell are ignored; presses are dropped, not queued.
  - RUN: drv_rst_n has bit mode_sel=1 and all others 0. led_out <= mode_led_bus slice [mode_sel], a 1-cycle registered latency. dwell_cnt increments while auto_en=1 and clears while auto_en=0.
- Advance occurs in RUN on a press event, or on auto_en=1 with dwell_cnt=DWELL_CYCLES-1. A simultaneous press and dwell expiry is exactly one advance. On the advance edge:
  - state→BLANK;
  - mode_sel→mode_sel+1, wrapping from NUM_MODES-1 to 0;
  - dwell_cnt→0;
  - mode_change=1 for that one cycle;
  - led_out and drv_rst_n go to 0 at that edge.
- Timing from power-up: the first RUN cycle follows BLANK_CYCLES cycles after reset release. The first nonzero led_out can appear 2 cycles after RUN entry: driver reset release, then the output register.
- mode_sel never holds a value ≥NUM_MODES. drv_rst_n bits ≥NUM_MODES stay 0 always.

Test Plan:
Use NUM_MODES=3, DEBOUNCE_CYCLES=4, DWELL_CYCLES=50, BLANK_CYCLES=8, and stub drivers outputting constants 8'h11/8'h22/8'h33 while released from reset, 0 otherwise.
1. Reset release, auto_en=0 → led_out=0 and drv_rst_n=000 for 8 cycles; then drv_rst_n=001; led_out=8'h11 two cycles later; steady thereafter with no mode_change.
2. Hold btn_n=0 for 10 cycles in RUN → exactly one mode_change pulse; 8 dark cycles; mode_sel=1, drv_rst_n=010, led_out=8'h22. A 2-cycle glitch on btn_n → no advance.
3. Three clean presses spaced >20 cycles apart → mode_sel sequence 1,2,0 (wrap); led_out 22,33,11.
4. auto_en=1 → advance every 50 RUN cycles plus 8 blank cycles (58-cycle period). A press landing on the dwell-expiry cycle → single advance (mode_sel +1, one mode_change).
5. Press during BLANK → ignored; mode_sel unchanged after RUN resumes; no extra mode_change.
6. rst_n=0 for one cycle mid-RUN at mode 2 → next cycle mode_sel=0, led_out=0, drv_rst_n=000, state BLANK; recovery as in scenario 1.
